// File: rtl/uart_pkg.sv
// Shared UART constants: default datapath widths for the baud generator
// and the default oversampling rate.
package uart_pkg;

  localparam int unsigned UART_DIV_W       = 16;
  localparam int unsigned UART_FRAC_W      = 4;
  localparam int unsigned UART_OSR_W       = 5;
  localparam int unsigned UART_OSR_DEFAULT = 16;

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional-divisor accumulator: works out the length of the current
// interval as div_int plus the carry out of acc + div_frac.
module baud_frac_acc
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W  = UART_DIV_W,
  parameter int unsigned FRAC_W = UART_FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              step,
  input  logic              clear,
  output logic [DIV_W:0]    period
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum;

  assign sum    = {1'b0, acc_q} + {1'b0, div_frac};
  assign period = {1'b0, div_int} + {{DIV_W{1'b0}}, sum[FRAC_W]};

  // The accumulator advances on the edge that ends an interval, so the
  // next interval's length is decided by the new accumulator value.
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = sum[FRAC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Fractional baud-rate generator: oversample, bit and mid-bit ticks with
// shadowed configuration that is applied on interval boundaries.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W  = UART_DIV_W,
  parameter int unsigned FRAC_W = UART_FRAC_W,
  parameter int unsigned OSR_W  = UART_OSR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cfg_load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic [OSR_W-1:0]  osr,
  input  logic              resync,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              mid_tick,
  output logic              cfg_pending
);

  logic [DIV_W-1:0]  div_q, div_d, sh_div_q, sh_div_d;
  logic [FRAC_W-1:0] frac_q, frac_d, sh_frac_q, sh_frac_d;
  logic [OSR_W-1:0]  osr_q, osr_d, sh_osr_q, sh_osr_d;
  logic              pend_q, pend_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [OSR_W-1:0]  os_cnt_q, os_cnt_d;

  logic [DIV_W:0]    period, period_m1;
  logic [OSR_W-1:0]  osr_eff, osr_last, osr_half, osr_mid;
  logic              stalled, interval_end, tick, os_wrap, apply, acc_clear;

  assign acc_clear = !en || resync;

  baud_frac_acc #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_int  (div_q),
    .div_frac (frac_q),
    .step     (tick),
    .clear    (acc_clear),
    .period   (period)
  );

  assign stalled      = (div_q == '0);
  assign period_m1    = period - (DIV_W+1)'(1);
  assign interval_end = ({1'b0, div_cnt_q} >= period_m1);
  assign tick         = en && !resync && !stalled && interval_end;

  assign osr_eff  = (osr_q == '0) ? OSR_W'(1) : osr_q;
  assign osr_last = osr_eff - OSR_W'(1);
  assign osr_half = osr_eff >> 1;
  assign osr_mid  = (osr_half == '0) ? '0 : osr_half - OSR_W'(1);
  // >= rather than == so a shrinking osr cannot strand os_cnt above the wrap point
  assign os_wrap  = (os_cnt_q >= osr_last);

  assign os_tick     = tick;
  assign bit_tick    = tick && os_wrap;
  assign mid_tick    = tick && (os_cnt_q == osr_mid);
  assign cfg_pending = pend_q;

  // While not producing ticks there is no boundary to wait for.
  assign apply = pend_q && (tick || !en || stalled);

  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    os_cnt_d  = os_cnt_q;
    if (!en || resync || stalled) begin
      div_cnt_d = '0;
      os_cnt_d  = '0;
    end else if (tick) begin
      div_cnt_d = '0;
      os_cnt_d  = os_wrap ? '0 : os_cnt_q + OSR_W'(1);
    end
  end

  // A load on the apply edge refills the shadow and stays pending.
  always_comb begin
    sh_div_d  = sh_div_q;
    sh_frac_d = sh_frac_q;
    sh_osr_d  = sh_osr_q;
    div_d     = div_q;
    frac_d    = frac_q;
    osr_d     = osr_q;
    pend_d    = pend_q;
    if (apply) begin
      div_d  = sh_div_q;
      frac_d = sh_frac_q;
      osr_d  = sh_osr_q;
      pend_d = 1'b0;
    end
    if (cfg_load) begin
      sh_div_d  = div_int;
      sh_frac_d = div_frac;
      sh_osr_d  = osr;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      os_cnt_q  <= '0;
      div_q     <= '0;
      frac_q    <= '0;
      osr_q     <= '0;
      sh_div_q  <= '0;
      sh_frac_q <= '0;
      sh_osr_q  <= '0;
      pend_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      os_cnt_q  <= os_cnt_d;
      div_q     <= div_d;
      frac_q    <= frac_d;
      osr_q     <= osr_d;
      sh_div_q  <= sh_div_d;
      sh_frac_q <= sh_frac_d;
      sh_osr_q  <= sh_osr_d;
      pend_q    <= pend_d;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: per-cycle expected {os,bit,mid,pend} vectors are
// queued as stimulus is driven and compared shortly after each falling edge.
module tb_baud_tick_gen;
  import uart_pkg::*;

  localparam int unsigned DW = UART_DIV_W;
  localparam int unsigned FW = UART_FRAC_W;
  localparam int unsigned OW = UART_OSR_W;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          en       = 1'b0;
  logic          cfg_load = 1'b0;
  logic          resync   = 1'b0;
  logic [DW-1:0] div_int  = '0;
  logic [FW-1:0] div_frac = '0;
  logic [OW-1:0] osr      = '0;
  logic          os_tick, bit_tick, mid_tick, cfg_pending;

  always #5 clk = ~clk;

  baud_tick_gen #(
    .DIV_W  (DW),
    .FRAC_W (FW),
    .OSR_W  (OW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cfg_load    (cfg_load),
    .div_int     (div_int),
    .div_frac    (div_frac),
    .osr         (osr),
    .resync      (resync),
    .os_tick     (os_tick),
    .bit_tick    (bit_tick),
    .mid_tick    (mid_tick),
    .cfg_pending (cfg_pending)
  );

  typedef struct {
    string      name;
    logic [3:0] exp;
  } sb_t;

  typedef struct {
    logic          en;
    logic          ld;
    logic          rs;
    logic [DW-1:0] div;
    logic [OW-1:0] osr;
    logic [3:0]    exp;
  } vec_t;

  sb_t         sb_q[$];
  sb_t         cur;
  vec_t        tbl[19];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  function automatic void check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: os/bit/mid/pend got %b, expected %b at %0t", name, got, exp, $time);
  endfunction

  function automatic vec_t mk(input logic e, input logic ld, input logic rs,
                              input int unsigned d, input int unsigned o, input logic [3:0] x);
    vec_t v;
    v.en  = e;
    v.ld  = ld;
    v.rs  = rs;
    v.div = DW'(d);
    v.osr = OW'(o);
    v.exp = x;
    return v;
  endfunction

  always begin
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      cur = sb_q.pop_front();
      check(cur.name, {os_tick, bit_tick, mid_tick, cfg_pending}, cur.exp);
    end
  end

  task automatic step(input logic e, input logic ld, input logic rs, input logic [DW-1:0] d,
                      input logic [FW-1:0] f, input logic [OW-1:0] o,
                      input logic [3:0] exp, input string name);
    @(negedge clk);
    en       = e;
    cfg_load = ld;
    resync   = rs;
    div_int  = d;
    div_frac = f;
    osr      = o;
    sb_q.push_back('{name, exp});
  endtask

  task automatic hold(input logic [3:0] exp, input string name);
    step(en, 1'b0, 1'b0, div_int, div_frac, osr, exp, name);
  endtask

  // div 4, osr 16, no fraction, counted from the first cycle of an interval
  task automatic run_fixed(input int unsigned n, input string name);
    for (int unsigned c = 0; c < n; c++)
      step(1'b1, 1'b0, 1'b0, div_int, div_frac, osr,
           {(c % 4) == 3, (c % 64) == 63, (c % 64) == 31, 1'b0}, name);
  endtask

  // Interval k (1-based) of div 4 ends after 4k + floor(k*f/16) cycles.
  task automatic run_frac(input int unsigned f, input int unsigned n, input string name);
    int unsigned k     = 1;
    int unsigned end_c = 4 + f / 16;
    int unsigned total = 4 * n + (f * n) / 16;
    logic        os;
    for (int unsigned c = 0; c < total; c++) begin
      os = (c + 1 == end_c);
      step(1'b1, 1'b0, 1'b0, div_int, div_frac, osr,
           {os, os && (k % 16 == 0), os && (k % 16 == 8), 1'b0}, name);
      if (os) begin
        k++;
        end_c = 4 * k + (f * k) / 16;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, expected end before %0t", $time);
    $fatal(1);
  end

  initial begin
    // Idle, no-config, en-low load, div 1 / osr 0, en drop, resync, coincident load.
    tbl[0]  = mk(1, 0, 0, 7, 0,  4'b0000);
    tbl[1]  = mk(1, 0, 0, 7, 0,  4'b0000);
    tbl[2]  = mk(0, 1, 0, 1, 0,  4'b0000);
    tbl[3]  = mk(0, 0, 0, 1, 0,  4'b0001);
    tbl[4]  = mk(0, 0, 0, 1, 0,  4'b0000);
    tbl[5]  = mk(1, 0, 0, 1, 0,  4'b1110);
    tbl[6]  = mk(1, 0, 0, 1, 0,  4'b1110);
    tbl[7]  = mk(1, 0, 0, 1, 0,  4'b1110);
    tbl[8]  = mk(0, 0, 0, 1, 0,  4'b0000);
    tbl[9]  = mk(0, 0, 0, 1, 0,  4'b0000);
    tbl[10] = mk(1, 0, 0, 1, 0,  4'b1110);
    tbl[11] = mk(1, 0, 1, 1, 0,  4'b0000);
    tbl[12] = mk(1, 0, 0, 1, 0,  4'b1110);
    tbl[13] = mk(1, 1, 0, 4, 16, 4'b1110);
    tbl[14] = mk(1, 0, 0, 4, 16, 4'b1111);
    tbl[15] = mk(1, 0, 0, 4, 16, 4'b0000);
    tbl[16] = mk(1, 0, 0, 4, 16, 4'b0000);
    tbl[17] = mk(1, 0, 0, 4, 16, 4'b0000);
    tbl[18] = mk(1, 0, 0, 4, 16, 4'b1000);

    step(1'b1, 1'b1, 1'b0, DW'(5), '0, OW'(UART_OSR_DEFAULT), 4'b0000, "in_reset");
    step(1'b1, 1'b1, 1'b0, DW'(5), '0, OW'(UART_OSR_DEFAULT), 4'b0000, "in_reset");
    @(negedge clk);
    en       = 1'b0;
    cfg_load = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < 19; i++)
      step(tbl[i].en, tbl[i].ld, tbl[i].rs, tbl[i].div, '0, tbl[i].osr, tbl[i].exp,
           $sformatf("table[%0d]", i));

    step(1'b1, 1'b0, 1'b1, DW'(4), '0, OW'(16), 4'b0000, "resync_start");
    run_fixed(128, "div4_osr16");

    run_fixed(22, "pre_resync");
    step(1'b1, 1'b0, 1'b1, DW'(4), '0, OW'(16), 4'b0000, "resync_mid");
    run_fixed(64, "post_resync");

    // div 4 -> 10 mid-interval, then 10 -> 4 loaded on a tick
    hold(4'b0000, "cfg_mid");
    step(1'b1, 1'b1, 1'b0, DW'(10), '0, OW'(16), 4'b0000, "cfg_mid");
    hold(4'b0001, "cfg_mid");
    hold(4'b1001, "cfg_mid");
    for (int i = 0; i < 9; i++) hold(4'b0000, "div10_first");
    step(1'b1, 1'b1, 1'b0, DW'(4), '0, OW'(16), 4'b1000, "cfg_on_tick");
    for (int i = 0; i < 9; i++) hold(4'b0001, "div10_pending");
    hold(4'b1001, "div10_pending");
    for (int i = 0; i < 3; i++) hold(4'b0000, "div4_again");
    hold(4'b1000, "div4_again");

    step(1'b0, 1'b1, 1'b0, DW'(4), FW'(8), OW'(16), 4'b0000, "frac8_load");
    hold(4'b0001, "frac8_load");
    hold(4'b0000, "frac8_load");
    run_frac(8, 32, "frac8");

    step(1'b0, 1'b1, 1'b0, DW'(4), FW'(1), OW'(16), 4'b0000, "frac1_load");
    hold(4'b0001, "frac1_load");
    hold(4'b0000, "frac1_load");
    run_frac(1, 20, "frac1");

    // Asynchronous reset while a tick and a pending load are visible
    hold(4'b0000, "pre_reset");
    step(1'b1, 1'b1, 1'b0, DW'(4), FW'(1), OW'(16), 4'b0000, "pre_reset");
    hold(4'b0001, "pre_reset");
    hold(4'b1001, "pre_reset");
    #2 rst_n = 1'b0;
    #1 check("async_reset", {os_tick, bit_tick, mid_tick, cfg_pending}, 4'b0000);
    @(negedge clk);
    rst_n    = 1'b1;
    cfg_load = 1'b0;
    for (int i = 0; i < 20; i++) hold(4'b0000, "no_tick_after_reset");

    step(1'b1, 1'b1, 1'b0, DW'(2), '0, OW'(2), 4'b0000, "osr2_load");
    hold(4'b0001, "osr2_load");
    hold(4'b0000, "osr2");
    hold(4'b1010, "osr2");
    hold(4'b0000, "osr2");
    hold(4'b1100, "osr2");
    step(1'b1, 1'b1, 1'b0, DW'(0), '0, OW'(2), 4'b0000, "div0_load");
    hold(4'b1011, "div0_load");
    for (int i = 0; i < 10; i++) hold(4'b0000, "div0_stall");

    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter DIV_W, default 16, width of integer divisor.
REQ-002 Parameter FRAC_W, default 4, width of fractional divisor (units of 1/2^FRAC_W clk).
REQ-003 Parameter OSR_W, default 5, width of oversampling-rate field.
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  generator enable; low = counters cleared, no ticks.
REQ-007 cfg_load  input  1  single-cycle pulse capturing div_int, div_frac, osr into shadow registers.
REQ-008 div_int  input  DIV_W  integer divisor, 0 = generator stalled.
REQ-009 div_frac  input  FRAC_W  fractional divisor.
REQ-010 osr  input  OSR_W  oversampling rate; 0 treated as 1.
REQ-011 resync  input  1  single-cycle pulse restarting tick phase (RX start-bit alignment).
REQ-012 os_tick  output  1  one-cycle oversample-rate pulse.
REQ-013 bit_tick  output  1  one-cycle bit-rate pulse, coincident with the os_tick ending each bit.
REQ-014 mid_tick  output  1  one-cycle pulse on the os_tick at mid-bit sample point.
REQ-015 cfg_pending  output  1  high while shadow config awaits application.

Function
REQ-016 Interval period SHALL be div_int + c cycles, c = carry-out of acc + div_frac (FRAC_W-bit accumulator, acc wraps mod 2^FRAC_W), acc updated at start of each interval.
REQ-017 Over any 2^FRAC_W consecutive intervals from acc=0, total cycles SHALL equal 2^FRAC_W*div_int + div_frac exactly.
REQ-018 div_cnt counts 0..period-1; os_tick SHALL assert in the cycle div_cnt == period-1, then div_cnt <= 0.
REQ-019 First os_tick after en sampled high (or after resync) SHALL occur at the period-th rising edge (div_int=1, div_frac=0 -> os_tick every cycle).
REQ-020 os_cnt counts os_ticks 0..osr_eff-1; bit_tick SHALL assert with the os_tick where os_cnt == osr_eff-1, os_cnt then wraps to 0.
REQ-021 mid_tick SHALL assert with the os_tick where os_cnt == osr_eff/2 - 1 (floor; osr_eff=1 -> every os_tick).
REQ-022 Active div_int == 0: no ticks, counters held at 0, acc held.
REQ-023 en low: div_cnt, os_cnt, acc cleared next edge; all tick outputs 0 combinationally gated by en.
REQ-024 resync SHALL clear div_cnt, os_cnt, acc; os_tick/bit_tick/mid_tick suppressed in the resync cycle; resync wins over a coincident tick.
REQ-025 cfg_load captures inputs to shadow; cfg_pending set next cycle; shadow copied to active config on the next os_tick edge, effective from the following interval; cfg_pending cleared same edge.
REQ-026 cfg_load in the same cycle as os_tick SHALL defer application to the subsequent os_tick.
REQ-027 en low or active div_int == 0: shadow applied on the edge after capture, cfg_pending never observed high beyond one cycle.
REQ-028 Repeated cfg_load while pending: latest values overwrite shadow; single application.

Reset
REQ-029 rst_n low: div_cnt, os_cnt, acc, shadow and active config = 0; os_tick, bit_tick, mid_tick, cfg_pending = 0.
REQ-030 Reset mid-interval SHALL abort immediately; after release no tick until cfg_load with nonzero div_int and en high.

Structure
REQ-031 Default widths DIV_W, FRAC_W, OSR_W and default OSR constant 16 SHALL live in shared package uart_pkg.
REQ-032 Fractional accumulator + period computation SHALL be sub-module baud_frac_acc (inputs div_int, div_frac, step, clear; output period).

Verification
REQ-033 div_int=4, div_frac=0, osr=16, en=1 -> os_tick every 4 cycles, bit_tick every 64, mid_tick at 32nd cycle of each bit.
REQ-034 div_int=4, div_frac=8 -> periods alternate 4,5; 16 intervals total 72 cycles; div_frac=1 -> one 5-cycle period per 16.
REQ-035 Change div_int 4->10 via cfg_load mid-interval -> current interval stays 4, next is 10; cfg_pending high between; cfg_load coincident with os_tick -> applied one tick later.
REQ-036 resync asserted at div_cnt=2 of a 4-cycle interval -> no tick that cycle, next os_tick 4 cycles later, os_cnt restarted (bit_tick after 16 os_ticks).
REQ-037 div_int=1, osr=0 -> os_tick, bit_tick, mid_tick high every cycle; en dropped -> all low next cycle, restart gives first tick 1 cycle after en.
REQ-038 rst_n asserted mid-bit -> all outputs 0 asynchronously; after release with en=1, no ticks until cfg_load.
